vec_proc_seq: RTL

- Parametrised, multi-cycle successor to the single-cycle SIMD processor. Executes one 16-bit instruction at a time over a 4-entry vector register file of LANES x LANE_W signed lanes.
- Adds a valid/ready instruction handshake, a variable-latency external memory port, a SUB op, a configurable-latency multiplier, and illegal-opcode reporting.
- Sits between the instruction source and the vector memory block.

---
 rtl/vec_proc_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/vec_proc_seq.sv
// vec_proc_seq: multi-cycle SIMD unit over a 4-entry vector register file.
// Handshaked intake, variable-latency memory port, multi-cycle MUL.
module vec_proc_seq #(
  parameter int LANES      = 16,
  parameter int LANE_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int MUL_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANES*LANE_W-1:0]   mem_wdata,
  input  logic [LANES*LANE_W-1:0]   mem_rdata,
  input  logic                      mem_rvalid,
  output logic [LANES*LANE_W-1:0]   r0,
  output logic [LANES*LANE_W-1:0]   r1,
  output logic [LANES*LANE_W-1:0]   r2,
  output logic [LANES*LANE_W-1:0]   r3,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal
);
  localparam int VW = LANES * LANE_W;
  localparam int W1 = LANE_W + 1;
  localparam int W2 = 2 * LANE_W;
  localparam int CW = $clog2(MUL_CYCLES + 1);

  localparam logic [2:0] OP_LD  = 3'b000;
  localparam logic [2:0] OP_ST  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [2:0] {
    IDLE, MRD_REQ, MRD_WAIT, MWR, EXEC, WB
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        ra_q, ra_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [VW-1:0]     x_q, x_d, y_q, y_d;
  logic [VW-1:0]     lo_q, lo_d, hi_q, hi_d;
  logic [VW-1:0]     rf_q [4];
  logic [VW-1:0]     rf_d [4];
  logic              ret_q, ret_d;
  logic              illp_q, illp_d;
  logic              done_q, done_d;
  logic              ill_q, ill_d;

  logic [VW-1:0]            res_lo, res_hi;
  logic signed [LANE_W-1:0] xs, ys;
  logic signed [LANE_W:0]   s;
  logic signed [W2-1:0]     wide;

  always_comb begin
    res_lo = '0;
    res_hi = '0;
    xs     = '0;
    ys     = '0;
    s      = '0;
    wide   = '0;
    for (int i = 0; i < LANES; i++) begin
      xs = x_q[i*LANE_W +: LANE_W];
      ys = y_q[i*LANE_W +: LANE_W];
      if (op_q == OP_SUB) s = W1'(xs) - W1'(ys);
      else                s = W1'(xs) + W1'(ys);
      if (op_q == OP_MUL) wide = W2'(xs) * W2'(ys);
      else                wide = W2'(s);
      res_lo[i*LANE_W +: LANE_W] = wide[LANE_W-1:0];
      res_hi[i*LANE_W +: LANE_W] = wide[W2-1:LANE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    addr_d  = addr_q;
    x_d     = x_q;
    y_d     = y_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rf_d    = rf_q;
    ret_d   = 1'b0;
    illp_d  = 1'b0;
    done_d  = ret_q;
    ill_d   = illp_q;
    unique case (state_q)
      IDLE: if (instr_valid) begin
        // Only legal, non-NOP ops touch the snapshot registers.
        case (instr[15:13])
          OP_LD, OP_ST, OP_ADD, OP_MUL, OP_SUB: begin
            op_d   = instr[15:13];
            ra_d   = instr[12:11];
            addr_d = instr[ADDR_W-1:0];
            x_d    = rf_q[instr[12:11]];
            y_d    = rf_q[instr[10:9]];
            if (instr[15:13] == OP_LD)      state_d = MRD_REQ;
            else if (instr[15:13] == OP_ST) state_d = MWR;
            else begin
              state_d = EXEC;
              cnt_d   = (instr[15:13] == OP_MUL) ? CW'(MUL_CYCLES) : CW'(1);
            end
          end
          OP_NOP:  ret_d  = 1'b1;
          default: illp_d = 1'b1;
        endcase
      end
      MRD_REQ: state_d = MRD_WAIT;
      MRD_WAIT: if (mem_rvalid) begin
        rf_d[ra_q] = mem_rdata;
        state_d    = IDLE;
        done_d     = 1'b1;
      end
      MWR: begin
        state_d = IDLE;
        ret_d   = 1'b1;
      end
      EXEC: begin
        if (cnt_q == CW'(1)) begin
          lo_d    = res_lo;
          hi_d    = res_hi;
          state_d = WB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WB: begin
        rf_d[2] = lo_q;
        rf_d[3] = hi_q;
        state_d = IDLE;
        ret_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      for (int k = 0; k < 4; k++) rf_q[k] <= '0;
      ret_q   <= 1'b0;
      illp_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rf_q    <= rf_d;
      ret_q   <= ret_d;
      illp_q  <= illp_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_req     = (state_q == MRD_REQ) || (state_q == MWR);
  assign mem_we      = (state_q == MWR);
  assign mem_addr    = addr_q;
  assign mem_wdata   = x_q;
  assign r0          = rf_q[0];
  assign r1          = rf_q[1];
  assign r2          = rf_q[2];
  assign r3          = rf_q[3];
  assign done        = done_q;
  assign illegal     = ill_q;

endmodule
